// File: rtl/shift_reg_pkg.sv
// Shared constants and mode encodings for the parametrised shift register
// and its prescaler.
package shift_reg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        MODE_SHL = 2'b00,
        MODE_SHR = 2'b01,
        MODE_ROL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_reg_n_if.sv
// Control/observe bundle between game control, the shift register and the
// segment display driver.
interface shift_reg_n_if
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);

    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             Shift;
    logic             BitIn;
    logic [1:0]       Mode;
    logic             AutoEn;
    logic [CNT_W-1:0] Period;
    logic [WIDTH-1:0] RegContent;
    logic             BitOut;
    logic             StepDone;
    logic             Empty;

    modport master (
        output Load, LoadValue, Shift, BitIn, Mode, AutoEn, Period,
        input  RegContent, BitOut, StepDone, Empty
    );

    modport slave (
        input  Load, LoadValue, Shift, BitIn, Mode, AutoEn, Period,
        output RegContent, BitOut, StepDone, Empty
    );

endinterface

// File: rtl/tick_gen.sv
// Programmable prescaler: one-cycle Tick every Period+1 enabled cycles.
// Dropping En clears the count so the next run starts a full interval.
module tick_gen
    import shift_reg_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [CNT_W-1:0] Period,
    output logic             Tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    // >= rather than == so a Period lowered below the count fires at once
    always_comb begin
        Tick      = 1'b0;
        countNext = '0;
        if (En) begin
            if (count >= Period) begin
                Tick = 1'b1;
            end else begin
                countNext = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised shift/rotate register with parallel load and built-in
// auto-shift prescaler, feeding the segment display driver.
module shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter int unsigned     WIDTH = DEFAULT_WIDTH,
    parameter int unsigned     CNT_W = DEFAULT_CNT_W,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic          Clk,
    input  logic          Rst,
    shift_reg_n_if.slave  bus
);

    logic             tick;
    logic             step;
    logic             autoRun;
    logic [WIDTH-1:0] regQ;
    logic [WIDTH-1:0] regNext;
    logic [WIDTH-1:0] stepVal;
    logic             stepBit;
    logic             bitQ;
    logic             bitNext;
    logic             doneQ;
    logic             doneNext;

    // Load wins over a tick and also restarts the auto-shift interval
    assign autoRun = bus.AutoEn & ~bus.Load;

    tick_gen #(
        .CNT_W (CNT_W)
    ) uTickGen (
        .Clk    (Clk),
        .Rst    (Rst),
        .En     (autoRun),
        .Period (bus.Period),
        .Tick   (tick)
    );

    // A manual step and an auto tick in the same cycle merge into one step
    assign step = bus.Shift | tick;

    always_comb begin
        stepVal = regQ;
        stepBit = 1'b0;
        case (mode_e'(bus.Mode))
            MODE_SHL: begin
                stepVal = {regQ[WIDTH-2:0], bus.BitIn};
                stepBit = regQ[WIDTH-1];
            end
            MODE_SHR: begin
                stepVal = {bus.BitIn, regQ[WIDTH-1:1]};
                stepBit = regQ[0];
            end
            MODE_ROL: begin
                stepVal = {regQ[WIDTH-2:0], regQ[WIDTH-1]};
                stepBit = regQ[WIDTH-1];
            end
            MODE_ROR: begin
                stepVal = {regQ[0], regQ[WIDTH-1:1]};
                stepBit = regQ[0];
            end
        endcase
    end

    always_comb begin
        regNext  = regQ;
        bitNext  = bitQ;
        doneNext = 1'b0;
        if (bus.Load) begin
            regNext  = bus.LoadValue;
            bitNext  = 1'b0;
            doneNext = 1'b1;
        end else if (step) begin
            regNext  = stepVal;
            bitNext  = stepBit;
            doneNext = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            regQ  <= INIT;
            bitQ  <= 1'b0;
            doneQ <= 1'b0;
        end else begin
            regQ  <= regNext;
            bitQ  <= bitNext;
            doneQ <= doneNext;
        end
    end

    assign bus.RegContent = regQ;
    assign bus.BitOut     = bitQ;
    assign bus.StepDone   = doneQ;
    assign bus.Empty      = (regQ == '0);

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n: reference model pushes expected state to a
// scoreboard queue each cycle, popped and compared after the clock edge.
module tb_shift_reg_n;
    import shift_reg_pkg::*;

    localparam int unsigned W  = 6;
    localparam int unsigned CW = 8;
    localparam logic [W-1:0] INIT_V = 6'b110010;

    logic clk;
    logic rst;

    shift_reg_n_if #(.WIDTH(W), .CNT_W(CW)) bus();

    shift_reg_n #(
        .WIDTH (W),
        .CNT_W (CW),
        .INIT  (INIT_V)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] r;
        logic         b;
        logic         d;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  mReg;
    logic          mBit;
    logic [CW-1:0] mCnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mReg = INIT_V;
        mBit = 1'b0;
        mCnt = '0;
    endtask

    // One clock of stimulus; the model predicts the post-edge state
    task automatic cyc(input string tag, input logic ld, input logic [W-1:0] lv,
                       input logic sh, input logic bi, input logic [1:0] md,
                       input logic ae, input logic [CW-1:0] per);
        logic tk;
        exp_t e;
        bus.Load      = ld;
        bus.LoadValue = lv;
        bus.Shift     = sh;
        bus.BitIn     = bi;
        bus.Mode      = md;
        bus.AutoEn    = ae;
        bus.Period    = per;

        tk = ae && !ld && (mCnt >= per);
        if (!ae || ld || tk) mCnt = '0;
        else mCnt = mCnt + CW'(1);

        e.d = 1'b0;
        if (ld) begin
            mReg = lv;
            mBit = 1'b0;
            e.d  = 1'b1;
        end else if (sh || tk) begin
            e.d = 1'b1;
            case (md)
                2'b00: begin mBit = mReg[W-1]; mReg = W'(mReg << 1) | W'(bi); end
                2'b01: begin mBit = mReg[0];   mReg = (mReg >> 1) | W'({bi, {(W-1){1'b0}}}); end
                2'b10: begin mBit = mReg[W-1]; mReg = W'(mReg << 1) | (mReg >> (W-1)); end
                default: begin mBit = mReg[0]; mReg = (mReg >> 1) | W'(mReg << (W-1)); end
            endcase
        end
        e.r = mReg;
        e.b = mBit;
        sbq.push_back(e);

        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, ".reg"},   32'(bus.RegContent), 32'(e.r));
        check({tag, ".bit"},   32'(bus.BitOut),     32'(e.b));
        check({tag, ".done"},  32'(bus.StepDone),   32'(e.d));
        check({tag, ".empty"}, 32'(bus.Empty),      32'(e.r == '0));
    endtask

    initial begin
        rst           = 1'b0;
        bus.Load      = 1'b0;
        bus.LoadValue = '0;
        bus.Shift     = 1'b0;
        bus.BitIn     = 1'b0;
        bus.Mode      = MODE_SHL;
        bus.AutoEn    = 1'b0;
        bus.Period    = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst.reg",   32'(bus.RegContent), 32'(INIT_V));
        check("rst.bit",   32'(bus.BitOut),     32'd0);
        check("rst.done",  32'(bus.StepDone),   32'd0);
        check("rst.empty", 32'(bus.Empty),      32'd0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Shift left with BitIn=1, then one idle cycle to see the pulse end
        cyc("shl", 1'b0, '0, 1'b1, 1'b1, MODE_SHL, 1'b0, '0);
        check("shl.const", 32'(bus.RegContent), 32'(6'b100101));
        cyc("shl_idle", 1'b0, '0, 1'b0, 1'b0, MODE_SHL, 1'b0, '0);

        // Asynchronous reset mid-cycle takes effect before the next edge
        #2 rst = 1'b1;
        #1;
        check("arst.reg",  32'(bus.RegContent), 32'(INIT_V));
        check("arst.bit",  32'(bus.BitOut),     32'd0);
        check("arst.done", 32'(bus.StepDone),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();

        // Three rotate-right steps from INIT
        for (int i = 0; i < 3; i++)
            cyc("ror", 1'b0, '0, 1'b1, 1'b1, MODE_ROR, 1'b0, '0);
        check("ror.const", 32'(bus.RegContent), 32'(6'b010110));

        // Shift right with BitIn=1
        cyc("shr", 1'b0, '0, 1'b1, 1'b1, MODE_SHR, 1'b0, '0);

        // Load beats a simultaneous shift
        cyc("ldsh", 1'b1, 6'b000000, 1'b1, 1'b1, MODE_SHL, 1'b0, '0);
        check("ldsh.empty", 32'(bus.Empty), 32'd1);

        // AutoEn=0 never ticks, even with Period=0
        cyc("ld1", 1'b1, 6'b000001, 1'b0, 1'b0, MODE_ROL, 1'b0, '0);
        for (int i = 0; i < 3; i++)
            cyc("noauto", 1'b0, '0, 1'b0, 1'b0, MODE_ROL, 1'b0, '0);
        check("noauto.const", 32'(bus.RegContent), 32'(6'b000001));

        // Auto rotate every Period+1 = 4 cycles
        cyc("ldauto", 1'b1, 6'b000001, 1'b0, 1'b0, MODE_ROL, 1'b1, CW'(3));
        for (int i = 0; i < 12; i++)
            cyc("auto", 1'b0, '0, 1'b0, 1'b0, MODE_ROL, 1'b1, CW'(3));
        check("auto.const", 32'(bus.RegContent), 32'(6'b001000));

        // Lower Period to 0 mid-count: immediate tick, then every cycle
        for (int i = 0; i < 2; i++)
            cyc("pre", 1'b0, '0, 1'b0, 1'b0, MODE_ROL, 1'b1, CW'(3));
        for (int i = 0; i < 3; i++)
            cyc("per0", 1'b0, '0, 1'b0, 1'b0, MODE_ROL, 1'b1, '0);
        check("per0.const", 32'(bus.RegContent), 32'(6'b000001));

        // Manual shift coinciding with an auto tick gives one step only
        cyc("ldco", 1'b1, 6'b000001, 1'b0, 1'b0, MODE_ROL, 1'b1, CW'(3));
        for (int i = 0; i < 3; i++)
            cyc("coin_wait", 1'b0, '0, 1'b0, 1'b0, MODE_ROL, 1'b1, CW'(3));
        cyc("coin", 1'b0, '0, 1'b1, 1'b0, MODE_ROL, 1'b1, CW'(3));
        check("coin.const", 32'(bus.RegContent), 32'(6'b000010));
        cyc("coin_idle", 1'b0, '0, 1'b0, 1'b0, MODE_ROL, 1'b0, CW'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
